ahb_sram_slave: RTL and testbench

AHB slave with a word-organised on-chip SRAM, sitting directly downstream of the CPU AHB master. It consumes the master's address/control/write-data outputs and returns hReadyout, hResp and hRdata on the loopback path. Wait states are programmable, and out-of-range or illegal transfers get a two-cycle ERROR response. One instance sits per slave-select code.

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/sp_sram.sv | 28 ++
 rtl/ahb_sram_slave.sv | 166 ++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave FSM state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR1 = 2'b10,
      ST_ERR2 = 2'b11
   } slaveState_t;

endpackage

// File: rtl/sp_sram.sv
// Word array with byte-lane write enables. The read word is combinational,
// so a word sampled on the same edge as a write shows the pre-write
// contents (read-first); the parent merges in-flight write lanes itself.
module sp_sram #(
   parameter int ADDR_W = 10
) (
   input  logic              hClk,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [3:0]        wrEn,
   input  logic [31:0]       wrData,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [31:0]       rdData
);

   logic [31:0] mem [2**ADDR_W];

   // Byte-lane write; lanes with a clear enable keep their old contents.
   always_ff @(posedge hClk) begin
      for (int i = 0; i < 4; i++) begin
         if (wrEn[i]) begin
            mem[wrAddr][8*i +: 8] <= wrData[8*i +: 8];
         end
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave in front of a word-organised SRAM with programmable wait
// states and a two-cycle ERROR response for illegal transfers.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | free, hReadyout=1; also the last cycle of an OKAY data phase
// WAIT    | inserted wait cycles, hReadyout=0, counter running down
// ERR1    | first ERROR cycle, hReadyout=0, hResp=1
// ERR2    | second ERROR cycle, hReadyout=1, hResp=1, may accept
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int         ADDR_W      = 10,
   parameter int         WAIT_STATES = 0,
   parameter logic [1:0] SLAVE_ID    = 2'b00
) (
   input  logic        hClk,
   input  logic        hRst,
   input  logic [1:0]  sel,
   input  logic [31:0] hAddr,
   input  logic        hWrite,
   input  logic [2:0]  hSize,
   input  logic [1:0]  hTrans,
   input  logic        hReady,
   input  logic [31:0] hWdata,
   output logic        hReadyout,
   output logic        hResp,
   output logic [31:0] hRdata
);

   slaveState_t       state;
   logic [3:0]        waitCnt;
   logic              dpValid;
   logic              dpWrite;
   logic [ADDR_W-1:0] dpWordAddr;
   logic [3:0]        dpMask;

   logic              accept;
   logic              outOfRange;
   logic              sizeBad;
   logic              misaligned;
   logic              legal;
   logic [3:0]        laneMask;
   logic [ADDR_W-1:0] addrWord;
   logic [ADDR_W-1:0] rdAddr;
   logic [31:0]       memWord;
   logic [31:0]       fwdWord;
   logic              wrCommit;
   logic              fwdHit;

   assign accept = hReadyout && (sel == SLAVE_ID) && hReady &&
                   ((hTrans == HTRANS_NONSEQ) || (hTrans == HTRANS_SEQ));

   assign outOfRange = |hAddr[31:ADDR_W+2];
   assign sizeBad    = hSize > HSIZE_WORD;
   assign addrWord   = hAddr[ADDR_W+1:2];
   assign legal      = !(outOfRange || sizeBad || misaligned);

   // Alignment and little-endian lane selection for the address phase.
   always_comb begin
      misaligned = 1'b0;
      laneMask   = 4'b1111;
      case (hSize)
         HSIZE_BYTE: laneMask = 4'b0001 << hAddr[1:0];
         HSIZE_HALF: begin
            misaligned = hAddr[0];
            laneMask   = hAddr[1] ? 4'b1100 : 4'b0011;
         end
         HSIZE_WORD: misaligned = |hAddr[1:0];
         default:    laneMask = 4'b1111;
      endcase
   end

   // A write commits on any edge that ends its data phase.
   assign wrCommit = hReadyout && dpValid && dpWrite;

   // Zero-wait reads sample the array at the accept edge; otherwise at the
   // edge leaving WAIT, from the captured address.
   assign rdAddr = (WAIT_STATES == 0) ? addrWord : dpWordAddr;
   assign fwdHit = wrCommit && (dpWordAddr == rdAddr);

   // Merge lanes of a write completing on the same edge into the read word.
   always_comb begin
      fwdWord = memWord;
      for (int i = 0; i < 4; i++) begin
         if (fwdHit && dpMask[i]) begin
            fwdWord[8*i +: 8] = hWdata[8*i +: 8];
         end
      end
   end

   sp_sram #(
      .ADDR_W (ADDR_W)
   ) uSram (
      .hClk   (hClk),
      .wrAddr (dpWordAddr),
      .wrEn   (dpMask & {4{wrCommit}}),
      .wrData (hWdata),
      .rdAddr (rdAddr),
      .rdData (memWord)
   );

   // Transfer FSM with registered bus responses and captured address phase.
   always_ff @(posedge hClk or posedge hRst) begin
      if (hRst) begin
         state      <= ST_IDLE;
         waitCnt    <= 4'd0;
         hReadyout  <= 1'b1;
         hResp      <= HRESP_OKAY;
         hRdata     <= 32'd0;
         dpValid    <= 1'b0;
         dpWrite    <= 1'b0;
         dpWordAddr <= '0;
         dpMask     <= 4'd0;
      end else if (accept) begin
         dpValid    <= legal;
         dpWrite    <= hWrite;
         dpWordAddr <= addrWord;
         dpMask     <= laneMask;
         if (!legal) begin
            state     <= ST_ERR1;
            hReadyout <= 1'b0;
            hResp     <= HRESP_ERROR;
         end else if (WAIT_STATES == 0) begin
            state     <= ST_IDLE;
            hReadyout <= 1'b1;
            hResp     <= HRESP_OKAY;
            if (!hWrite) begin
               hRdata <= fwdWord;
            end
         end else begin
            state     <= ST_WAIT;
            waitCnt   <= 4'(WAIT_STATES);
            hReadyout <= 1'b0;
            hResp     <= HRESP_OKAY;
         end
      end else begin
         case (state)
            ST_WAIT: begin
               if (waitCnt == 4'd1) begin
                  state     <= ST_IDLE;
                  waitCnt   <= 4'd0;
                  hReadyout <= 1'b1;
                  if (!dpWrite) begin
                     hRdata <= fwdWord;
                  end
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               hReadyout <= 1'b1;
               hResp     <= HRESP_ERROR;
            end
            default: begin
               state     <= ST_IDLE;
               hReadyout <= 1'b1;
               hResp     <= HRESP_OKAY;
               dpValid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one zero-wait instance and one three-wait
// instance on a shared bus, table vectors, hand sequences and random
// traffic against a sequential memory model.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   logic        hClk = 1'b0;
   logic        hRst = 1'b1;
   logic [1:0]  sel = 2'b11;
   logic [31:0] hAddr = 32'd0;
   logic        hWrite = 1'b0;
   logic [2:0]  hSize = HSIZE_WORD;
   logic [1:0]  hTrans = HTRANS_IDLE;
   logic        hReady = 1'b1;
   logic [31:0] hWdata = 32'd0;

   logic        rdy0, rdy1, resp0, resp1;
   logic [31:0] rdat0, rdat1;

   int nChecks = 0;
   int nFail = 0;

   logic [31:0] refMem [0:1][0:1023];
   logic [31:0] lastRd [0:1];

   typedef struct {
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        expErr;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecs[$];

   ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0), .SLAVE_ID(2'b00)) dutWs0 (
      .hClk(hClk), .hRst(hRst), .sel(sel), .hAddr(hAddr), .hWrite(hWrite),
      .hSize(hSize), .hTrans(hTrans), .hReady(hReady), .hWdata(hWdata),
      .hReadyout(rdy0), .hResp(resp0), .hRdata(rdat0));

   ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(3), .SLAVE_ID(2'b01)) dutWs3 (
      .hClk(hClk), .hRst(hRst), .sel(sel), .hAddr(hAddr), .hWrite(hWrite),
      .hSize(hSize), .hTrans(hTrans), .hReady(hReady), .hWdata(hWdata),
      .hReadyout(rdy1), .hResp(resp1), .hRdata(rdat1));

   always #5 hClk = ~hClk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic rdyOf(input int s);
      return (s == 0) ? rdy0 : rdy1;
   endfunction

   function automatic logic respOf(input int s);
      return (s == 0) ? resp0 : resp1;
   endfunction

   function automatic logic [31:0] rdatOf(input int s);
      return (s == 0) ? rdat0 : rdat1;
   endfunction

   function automatic int wsOf(input int s);
      return (s == 0) ? 0 : 3;
   endfunction

   function automatic vec_t mkVec(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic expErr, input logic [31:0] expRd);
      vec_t v;
      v.wr = wr; v.sz = sz; v.addr = addr; v.wd = wd; v.expErr = expErr; v.expRd = expRd;
      return v;
   endfunction

   // Legal: inside 4 KiB, size at most a word, address a multiple of the size.
   function automatic bit refLegal(input logic [31:0] addr, input logic [2:0] sz);
      if (sz > 3'd2) return 1'b0;
      if (addr >= 32'h1000) return 1'b0;
      return (addr % (32'd1 << sz)) == 32'd0;
   endfunction

   function automatic void refWrite(input int s, input logic [31:0] addr, input logic [2:0] sz,
                                    input logic [31:0] wd);
      int idx = int'(addr >> 2);
      int first = int'(addr % 4);
      for (int b = 0; b < (1 << sz); b++) begin
         refMem[s][idx][(first + b) * 8 +: 8] = wd[(first + b) * 8 +: 8];
      end
   endfunction

   task automatic step();
      @(posedge hClk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Single isolated transfer, checking the whole response shape.
   task automatic doXfer(input int s, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input logic expErr, input logic [31:0] expRd,
                         input string nm);
      int low;
      sel = (s == 0) ? 2'b00 : 2'b01;
      hAddr = addr; hWrite = wr; hSize = sz; hTrans = HTRANS_NONSEQ; hReady = 1'b1;
      chk({nm, "_free"}, 32'(rdyOf(s)), 32'd1);
      step();
      hTrans = HTRANS_IDLE;
      hWdata = wd;
      if (expErr) begin
         chk({nm, "_err1_rdy"}, 32'(rdyOf(s)), 32'd0);
         chk({nm, "_err1_resp"}, 32'(respOf(s)), 32'd1);
         hTrans = HTRANS_NONSEQ; hAddr = 32'h0000_4000;
         step();
         hTrans = HTRANS_IDLE;
         chk({nm, "_err2_rdy"}, 32'(rdyOf(s)), 32'd1);
         chk({nm, "_err2_resp"}, 32'(respOf(s)), 32'd1);
         step();
         chk({nm, "_after_rdy"}, 32'(rdyOf(s)), 32'd1);
         chk({nm, "_after_resp"}, 32'(respOf(s)), 32'd0);
         chk({nm, "_rdata_held"}, rdatOf(s), lastRd[s]);
      end else begin
         low = 0;
         while (rdyOf(s) == 1'b0 && low < 20) begin
            hTrans = HTRANS_NONSEQ; hAddr = 32'h0000_4000;
            step();
            low++;
         end
         hTrans = HTRANS_IDLE;
         chk({nm, "_waits"}, 32'(low), 32'(wsOf(s)));
         chk({nm, "_resp"}, 32'(respOf(s)), 32'd0);
         if (!wr) lastRd[s] = expRd;
         chk({nm, "_rdata"}, rdatOf(s), lastRd[s]);
         step();
         chk({nm, "_end_rdy"}, 32'(rdyOf(s)), 32'd1);
      end
   endtask

   // Write immediately followed by a read issued on the write's last cycle.
   task automatic pipePair(input int s, input logic [31:0] wAddr, input logic [2:0] wSz,
                           input logic [31:0] wd, input logic [31:0] rAddr,
                           input logic [31:0] expRd, input string nm);
      int low;
      sel = (s == 0) ? 2'b00 : 2'b01;
      hAddr = wAddr; hWrite = 1'b1; hSize = wSz; hTrans = HTRANS_NONSEQ; hReady = 1'b1;
      step();
      hTrans = HTRANS_IDLE;
      hWdata = wd;
      low = 0;
      while (rdyOf(s) == 1'b0 && low < 20) begin
         step();
         low++;
      end
      hAddr = rAddr; hWrite = 1'b0; hSize = HSIZE_WORD; hTrans = HTRANS_NONSEQ;
      step();
      hTrans = HTRANS_IDLE;
      refWrite(s, wAddr, wSz, wd);
      low = 0;
      while (rdyOf(s) == 1'b0 && low < 20) begin
         step();
         low++;
      end
      chk({nm, "_rd_waits"}, 32'(low), 32'(wsOf(s)));
      chk({nm, "_rd_resp"}, 32'(respOf(s)), 32'd0);
      chk({nm, "_rd_data"}, rdatOf(s), expRd);
      lastRd[s] = expRd;
      step();
   endtask

   // Back-to-back random traffic on the zero-wait instance.
   task automatic pipeRandom(input int n);
      logic [31:0] pendWd;
      logic [31:0] exp;
      bit isRd;
      pendWd = 32'd0;
      exp = 32'd0;
      sel = 2'b00; hReady = 1'b1;
      for (int i = 0; i < n; i++) begin
         int w;
         int off;
         logic [2:0] sz;
         logic [31:0] a;
         hWdata = pendWd;
         isRd = 1'b0;
         if (i >= 8 && $urandom_range(0, 3) == 0) begin
            hTrans = HTRANS_IDLE;
         end else begin
            w = (i < 8) ? i : int'($urandom_range(0, 7));
            sz = (i < 8) ? HSIZE_WORD : 3'($urandom_range(0, 2));
            off = (sz == HSIZE_WORD) ? 0 :
                  (sz == HSIZE_HALF) ? 2 * int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
            a = 32'h400 + 32'(4 * w + off);
            hAddr = a; hSize = sz; hTrans = HTRANS_NONSEQ;
            hWrite = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            if (hWrite) begin
               pendWd = $urandom();
               refWrite(0, a, sz, pendWd);
            end else begin
               isRd = 1'b1;
               exp = refMem[0][int'(a >> 2)];
            end
         end
         chk($sformatf("pipe_rdy_%0d", i), 32'(rdy0), 32'd1);
         step();
         if (isRd) begin
            lastRd[0] = exp;
            chk($sformatf("pipe_rdata_%0d", i), rdat0, exp);
         end
      end
      hTrans = HTRANS_IDLE;
      hWdata = pendWd;
      step();
   endtask

   // Isolated random transfers, legal and illegal, on the wait-state instance.
   task automatic xferRandom(input int n);
      for (int w = 0; w < 8; w++) begin
         logic [31:0] d;
         d = $urandom();
         doXfer(1, 1'b1, HSIZE_WORD, 32'h400 + 32'(4 * w), d, 1'b0, 32'd0, $sformatf("pf3_%0d", w));
         refWrite(1, 32'h400 + 32'(4 * w), HSIZE_WORD, d);
      end
      for (int i = 0; i < n; i++) begin
         int kind;
         int off;
         logic [2:0] sz;
         logic [31:0] a;
         logic [31:0] wd;
         logic wr;
         bit ok;
         kind = int'($urandom_range(0, 9));
         sz = (kind == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         off = int'($urandom_range(0, 3));
         if (kind > 2 && sz <= 3'd2) off = off & ~((1 << sz) - 1);
         a = 32'h400 + 32'(4 * int'($urandom_range(0, 7)) + off);
         if (kind == 2) a = a + (32'd1 << $urandom_range(12, 31));
         wr = 1'($urandom_range(0, 1));
         wd = $urandom();
         ok = refLegal(a, sz);
         doXfer(1, wr, sz, a, wd, !ok, ok ? refMem[1][int'(a[11:2])] : 32'd0,
                $sformatf("rnd3_%0d", i));
         if (ok && wr) refWrite(1, a, sz, wd);
      end
   endtask

   initial begin
      logic [1:0] uSel [4];
      logic [1:0] uTrans [4];
      logic       uReady [4];

      vecs.push_back(mkVec(1'b1, HSIZE_WORD, 32'h010,  32'hDEADBEEF, 1'b0, 32'h0));
      vecs.push_back(mkVec(1'b0, HSIZE_WORD, 32'h010,  32'h0,        1'b0, 32'hDEADBEEF));
      vecs.push_back(mkVec(1'b1, HSIZE_WORD, 32'h010,  32'h11223344, 1'b0, 32'h0));
      vecs.push_back(mkVec(1'b1, HSIZE_BYTE, 32'h011,  32'hFFFFAAFF, 1'b0, 32'h0));
      vecs.push_back(mkVec(1'b0, HSIZE_WORD, 32'h010,  32'h0,        1'b0, 32'h1122AA44));
      vecs.push_back(mkVec(1'b1, HSIZE_HALF, 32'h012,  32'h5566FFFF, 1'b0, 32'h0));
      vecs.push_back(mkVec(1'b0, HSIZE_WORD, 32'h010,  32'h0,        1'b0, 32'h5566AA44));
      vecs.push_back(mkVec(1'b0, HSIZE_BYTE, 32'h013,  32'h0,        1'b0, 32'h5566AA44));
      vecs.push_back(mkVec(1'b1, HSIZE_WORD, 32'h1002, 32'h0BAD0BAD, 1'b1, 32'h0));
      vecs.push_back(mkVec(1'b1, HSIZE_WORD, 32'h4000, 32'h0BAD0BAD, 1'b1, 32'h0));
      vecs.push_back(mkVec(1'b1, HSIZE_WORD, 32'h4010, 32'h0BAD0BAD, 1'b1, 32'h0));
      vecs.push_back(mkVec(1'b1, HSIZE_WORD, 32'h012,  32'h0BAD0BAD, 1'b1, 32'h0));
      vecs.push_back(mkVec(1'b1, 3'b011,     32'h010,  32'h0BAD0BAD, 1'b1, 32'h0));
      vecs.push_back(mkVec(1'b1, HSIZE_HALF, 32'h011,  32'h0BAD0BAD, 1'b1, 32'h0));
      vecs.push_back(mkVec(1'b0, 3'b111,     32'h010,  32'h0,        1'b1, 32'h0));
      vecs.push_back(mkVec(1'b0, HSIZE_WORD, 32'h010,  32'h0,        1'b0, 32'h5566AA44));
      vecs.push_back(mkVec(1'b1, HSIZE_WORD, 32'hFFC,  32'hCAFEF00D, 1'b0, 32'h0));
      vecs.push_back(mkVec(1'b0, HSIZE_WORD, 32'hFFC,  32'h0,        1'b0, 32'hCAFEF00D));
      vecs.push_back(mkVec(1'b0, HSIZE_HALF, 32'h012,  32'h0,        1'b0, 32'h5566AA44));
      vecs.push_back(mkVec(1'b1, HSIZE_BYTE, 32'h010,  32'hFFFFFF77, 1'b0, 32'h0));
      vecs.push_back(mkVec(1'b0, HSIZE_WORD, 32'h010,  32'h0,        1'b0, 32'h5566AA77));

      uSel   = '{2'b10, 2'b00, 2'b01, 2'b00};
      uTrans = '{HTRANS_NONSEQ, HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ};
      uReady = '{1'b1, 1'b1, 1'b1, 1'b0};

      // Reset values, sampled while reset is held.
      step();
      step();
      chk("rst_rdy0", 32'(rdy0), 32'd1);
      chk("rst_resp0", 32'(resp0), 32'd0);
      chk("rst_rdata0", rdat0, 32'd0);
      chk("rst_rdy1", 32'(rdy1), 32'd1);
      chk("rst_resp1", 32'(resp1), 32'd0);
      chk("rst_rdata1", rdat1, 32'd0);
      @(negedge hClk);
      hRst = 1'b0;
      step();
      lastRd[0] = 32'd0;
      lastRd[1] = 32'd0;

      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < vecs.size(); i++) begin
            doXfer(s, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].expErr,
                   vecs[i].expRd, $sformatf("vec_s%0d_%0d", s, i));
            if (!vecs[i].expErr && vecs[i].wr) refWrite(s, vecs[i].addr, vecs[i].sz, vecs[i].wd);
         end
      end

      // Unselected, IDLE, BUSY and not-ready cycles must be ignored.
      for (int i = 0; i < 4; i++) begin
         sel = uSel[i]; hTrans = uTrans[i]; hReady = uReady[i];
         hAddr = 32'h0000_4000; hWrite = 1'b0; hSize = HSIZE_WORD;
         step();
         hTrans = HTRANS_IDLE; hReady = 1'b1;
         chk($sformatf("ign_%0d_rdy0", i), 32'(rdy0), 32'd1);
         chk($sformatf("ign_%0d_resp0", i), 32'(resp0), 32'd0);
         chk($sformatf("ign_%0d_rdata0", i), rdat0, lastRd[0]);
         chk($sformatf("ign_%0d_rdy1", i), 32'(rdy1), 32'd1);
         chk($sformatf("ign_%0d_resp1", i), 32'(resp1), 32'd0);
         chk($sformatf("ign_%0d_rdata1", i), rdat1, lastRd[1]);
      end

      pipePair(0, 32'h030, HSIZE_WORD, 32'h0000CAFE, 32'h030, 32'h0000CAFE, "fwd_word");
      pipePair(0, 32'h034, HSIZE_WORD, 32'h12345678, 32'h030, 32'h0000CAFE, "fwd_other");
      pipePair(0, 32'h031, HSIZE_BYTE, 32'h0000EE00, 32'h030, 32'h0000EEFE, "fwd_byte");
      pipePair(0, 32'h036, HSIZE_HALF, 32'hBEEF0000, 32'h034, 32'hBEEF5678, "fwd_half");
      pipePair(1, 32'h050, HSIZE_WORD, 32'hA5A5A5A5, 32'h050, 32'hA5A5A5A5, "b2b_ws3");

      // Reset in the middle of a waited write drops that write.
      doXfer(1, 1'b1, HSIZE_WORD, 32'h040, 32'h11111111, 1'b0, 32'd0, "rst_pre");
      refWrite(1, 32'h040, HSIZE_WORD, 32'h11111111);
      sel = 2'b01; hAddr = 32'h040; hWrite = 1'b1; hSize = HSIZE_WORD; hTrans = HTRANS_NONSEQ;
      step();
      hTrans = HTRANS_IDLE;
      hWdata = 32'h22222222;
      chk("rst_mid_inwait", 32'(rdy1), 32'd0);
      step();
      #2;
      hRst = 1'b1;
      #1;
      chk("rst_mid_rdy0", 32'(rdy0), 32'd1);
      chk("rst_mid_resp0", 32'(resp0), 32'd0);
      chk("rst_mid_rdata0", rdat0, 32'd0);
      chk("rst_mid_rdy1", 32'(rdy1), 32'd1);
      chk("rst_mid_resp1", 32'(resp1), 32'd0);
      chk("rst_mid_rdata1", rdat1, 32'd0);
      lastRd[0] = 32'd0;
      lastRd[1] = 32'd0;
      @(negedge hClk);
      hRst = 1'b0;
      step();
      doXfer(1, 1'b0, HSIZE_WORD, 32'h040, 32'd0, 1'b0, 32'h11111111, "rst_post");

      pipeRandom(200);
      xferRandom(40);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
